// File: rtl/uart_threshold_reporter.sv
// Formats a captured threshold as "M=[-]digits[*HH]\r\n" and streams it into the uart transmit handshake.
// Optional checksum suffix enabled by defining THRESH_REPORT_CKSUM_EN.
module uart_threshold_reporter #(
  parameter int unsigned TX_GUARD = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        report_req,
  input  logic [7:0]  mode_char,
  input  logic [15:0] value,
  input  logic        value_is_signed,
  input  logic        idle_ready_tx,
  output logic [7:0]  data_tx,
  output logic        start_tx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CONVERT, S_SEND_WAIT, S_SEND_GUARD, S_DONE
  } state_t;

  localparam logic [3:0] GUARD_LAST = 4'(TX_GUARD - 1);

  state_t      state, state_nxt;
  logic [7:0]  mode_q;
  logic        neg_q;
  logic [15:0] rem_q;
  logic [2:0]  pow_idx;
  logic [3:0]  digit_cnt;
  logic [3:0]  dig_buf [5];
  logic [2:0]  first_idx;
  logic        seen_nz;
  logic [3:0]  byte_idx;
  logic [3:0]  guard_cnt;
  logic        capture, issue, advance, sub_ok;
  logic [7:0]  cur_byte;
  logic [3:0]  dig_base, dig_end, cr_pos;
  logic [2:0]  dig_sel;
  logic [7:0]  low_byte, low_mag;

  function automatic logic [15:0] pow10(input logic [2:0] idx);
    case (idx)
      3'd0:    pow10 = 16'd10000;
      3'd1:    pow10 = 16'd1000;
      3'd2:    pow10 = 16'd100;
      3'd3:    pow10 = 16'd10;
      default: pow10 = 16'd1;
    endcase
  endfunction

  assign low_byte = value[7:0];
  assign low_mag  = low_byte[7] ? (~low_byte + 8'd1) : low_byte;
  assign sub_ok   = rem_q >= pow10(pow_idx);

  // Line layout: mode, '=', optional '-', digits, [checksum], CR, LF.
  assign dig_base = neg_q ? 4'd3 : 4'd2;
  assign dig_end  = dig_base + 4'd5 - {1'b0, first_idx};
  assign dig_sel  = first_idx + 3'(byte_idx - dig_base);

`ifdef THRESH_REPORT_CKSUM_EN
  logic [7:0] cksum_q;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    hex_ascii = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  assign cr_pos = dig_end + 4'd3;
`else
  assign cr_pos = dig_end;
`endif

  always_comb begin
    cur_byte = 8'h0A;
    if (byte_idx == 4'd0)          cur_byte = mode_q;
    else if (byte_idx == 4'd1)     cur_byte = 8'h3D;
    else if (byte_idx < dig_base)  cur_byte = 8'h2D;
    else if (byte_idx < dig_end)   cur_byte = {4'h3, dig_buf[dig_sel]};
`ifdef THRESH_REPORT_CKSUM_EN
    else if (byte_idx == dig_end)          cur_byte = 8'h2A;
    else if (byte_idx == dig_end + 4'd1)   cur_byte = hex_ascii(cksum_q[7:4]);
    else if (byte_idx == dig_end + 4'd2)   cur_byte = hex_ascii(cksum_q[3:0]);
`endif
    else if (byte_idx == cr_pos)   cur_byte = 8'h0D;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    capture   = 1'b0;
    issue     = 1'b0;
    advance   = 1'b0;
    case (state)
      S_IDLE: if (report_req) begin
        capture   = 1'b1;
        state_nxt = S_CONVERT;
      end
      S_CONVERT: begin
        busy = 1'b1;
        if (!sub_ok && pow_idx == 3'd4) state_nxt = S_SEND_WAIT;
      end
      S_SEND_WAIT: begin
        busy = 1'b1;
        if (idle_ready_tx) begin
          issue     = 1'b1;
          state_nxt = S_SEND_GUARD;
        end
      end
      S_SEND_GUARD: begin
        busy = 1'b1;
        if (guard_cnt == GUARD_LAST) begin
          if (byte_idx == cr_pos + 4'd1) begin
            state_nxt = S_DONE;
          end else begin
            advance   = 1'b1;
            state_nxt = S_SEND_WAIT;
          end
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= '0;
      neg_q     <= 1'b0;
      rem_q     <= '0;
      pow_idx   <= '0;
      digit_cnt <= '0;
      first_idx <= '0;
      seen_nz   <= 1'b0;
      byte_idx  <= '0;
      guard_cnt <= '0;
      data_tx   <= '0;
      start_tx  <= 1'b0;
      for (int i = 0; i < 5; i++) dig_buf[i] <= '0;
`ifdef THRESH_REPORT_CKSUM_EN
      cksum_q   <= '0;
`endif
    end else begin
      start_tx <= issue;
      if (capture) begin
        mode_q    <= mode_char;
        neg_q     <= value_is_signed & low_byte[7];
        rem_q     <= value_is_signed ? {8'h00, low_mag} : value;
        pow_idx   <= '0;
        digit_cnt <= '0;
        first_idx <= 3'd4;
        seen_nz   <= 1'b0;
        byte_idx  <= '0;
        guard_cnt <= '0;
`ifdef THRESH_REPORT_CKSUM_EN
        cksum_q   <= '0;
`endif
      end
      // Restoring division: one subtraction or one power step per cycle.
      if (state == S_CONVERT) begin
        if (sub_ok) begin
          rem_q     <= rem_q - pow10(pow_idx);
          digit_cnt <= digit_cnt + 4'd1;
        end else begin
          dig_buf[pow_idx] <= digit_cnt;
          digit_cnt        <= '0;
          if (digit_cnt != 4'd0 && !seen_nz) begin
            first_idx <= pow_idx;
            seen_nz   <= 1'b1;
          end
          if (pow_idx != 3'd4) pow_idx <= pow_idx + 3'd1;
        end
      end
      if (issue) begin
        data_tx   <= cur_byte;
        guard_cnt <= '0;
`ifdef THRESH_REPORT_CKSUM_EN
        if (byte_idx < dig_end) cksum_q <= cksum_q ^ cur_byte;
`endif
      end else if (state == S_SEND_GUARD && guard_cnt != GUARD_LAST) begin
        guard_cnt <= guard_cnt + 4'd1;
      end
      if (advance) byte_idx <= byte_idx + 4'd1;
    end
  end

endmodule

// File: tb/tb_uart_threshold_reporter.sv
// Scoreboard bench for uart_threshold_reporter: expected lines come from printf-style formatting of the request.
module tb_uart_threshold_reporter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        report_req = 1'b0;
  logic [7:0]  mode_char = 8'h00;
  logic [15:0] value = 16'h0000;
  logic        value_is_signed = 1'b0;
  logic        idle_ready_tx = 1'b1;
  logic [7:0]  data_tx;
  logic        start_tx, busy, done;

  int checks = 0;
  int failures = 0;
  int strobe_cnt = 0;
  int done_cnt = 0;
  int stall_strobes = 0;
  bit stall_active = 1'b0;
  bit force_low = 1'b0;
  bit rand_ready = 1'b0;
  logic [7:0] exp_q[$];

  uart_threshold_reporter #(.TX_GUARD(2)) dut (
    .clk(clk), .rst(rst), .report_req(report_req), .mode_char(mode_char),
    .value(value), .value_is_signed(value_is_signed), .idle_ready_tx(idle_ready_tx),
    .data_tx(data_tx), .start_tx(start_tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes a byte.
  always @(negedge clk) begin
    if (!rst) begin
      if (start_tx) begin
        strobe_cnt++;
        if (stall_active) stall_strobes++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe: got %0h expected no byte", data_tx);
        end else begin
          check("tx_byte", {24'h0, data_tx}, {24'h0, exp_q.pop_front()});
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    idle_ready_tx = force_low ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
  endtask

  task automatic push_expected(input logic [7:0] m, input logic [15:0] v, input logic s);
    int    mag;
    bit    neg;
    string digits;
    logic [7:0] ck;
    neg = 1'b0;
    mag = v;
    if (s) begin
      mag = $signed(v[7:0]);
      if (mag < 0) begin
        neg = 1'b1;
        mag = -mag;
      end
    end
    digits = $sformatf("%0d", mag);
    exp_q.push_back(m);
    exp_q.push_back(8'h3D);
    ck = m ^ 8'h3D;
    if (neg) begin
      exp_q.push_back(8'h2D);
      ck ^= 8'h2D;
    end
    for (int i = 0; i < digits.len(); i++) begin
      exp_q.push_back(digits[i]);
      ck ^= digits[i];
    end
`ifdef THRESH_REPORT_CKSUM_EN
    begin
      string hx;
      hx = $sformatf("%02X", ck);
      exp_q.push_back(8'h2A);
      exp_q.push_back(hx[0]);
      exp_q.push_back(hx[1]);
    end
`endif
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic request(input logic [7:0] m, input logic [15:0] v, input logic s);
    report_req      = 1'b1;
    mode_char       = m;
    value           = v;
    value_is_signed = s;
    tick();
    report_req      = 1'b0;
    mode_char       = 8'($urandom);
    value           = 16'($urandom);
    value_is_signed = 1'($urandom);
  endtask

  // One full line; stall_after>=0 stalls the uart for 100 cycles after that many bytes,
  // extra_req re-pulses report_req mid-line, lat_check bounds the conversion latency.
  task automatic run_line(input logic [7:0] m, input logic [15:0] v, input logic s,
                          input int stall_after, input bit extra_req, input bit lat_check);
    int  base_strobe, base_done, cyc, first_cyc;
    bit  stalled;
    push_expected(m, v, s);
    base_strobe = strobe_cnt;
    base_done   = done_cnt;
    first_cyc   = -1;
    stalled     = 1'b0;
    request(m, v, s);
    check("busy_after_capture", {31'h0, busy}, 32'h1);
    for (cyc = 0; cyc < 5000 && done_cnt == base_done; cyc++) begin
      if (first_cyc < 0 && strobe_cnt != base_strobe) first_cyc = cyc;
      if (extra_req && cyc == 20) begin
        report_req = 1'b1;
        mode_char  = 8'h5A;
        value      = 16'd777;
      end else begin
        report_req = 1'b0;
      end
      if (!stalled && stall_after >= 0 && strobe_cnt - base_strobe == stall_after) begin
        stalled      = 1'b1;
        force_low    = 1'b1;
        stall_active = 1'b1;
        stall_strobes = 0;
        repeat (100) tick();
        check("no_strobe_during_stall", stall_strobes, 0);
        stall_active = 1'b0;
        force_low    = 1'b0;
      end
      tick();
    end
    report_req = 1'b0;
    check("line_completed_in_budget", {31'h0, cyc < 5000}, 32'h1);
    if (lat_check) check("convert_latency_ok", {31'h0, first_cyc >= 0 && first_cyc <= 53}, 32'h1);
    repeat (4) tick();
    check("single_done", done_cnt - base_done, 1);
    check("all_bytes_sent", exp_q.size(), 0);
    check("busy_low_after", {31'h0, busy}, 32'h0);
  endtask

  initial begin
    int base_strobe, base_done;
    repeat (3) tick();
    check("rst_start_tx", {31'h0, start_tx}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_data_tx", {24'h0, data_tx}, 32'h0);
    rst = 1'b0;
    repeat (2) tick();

    run_line("A", 16'd2550, 1'b0, -1, 1'b0, 1'b1);
    run_line("C", 16'h00F4, 1'b1, -1, 1'b0, 1'b1);
    run_line("C", 16'h0080, 1'b1, -1, 1'b0, 1'b1);
    run_line("B", 16'd0, 1'b0, -1, 1'b0, 1'b1);
    run_line("B", 16'd65535, 1'b0, -1, 1'b0, 1'b1);
    run_line("D", 16'h7F05, 1'b1, -1, 1'b0, 1'b1);
    run_line("E", 16'd1234, 1'b0, 2, 1'b0, 1'b0);
    run_line("F", 16'd40007, 1'b0, -1, 1'b1, 1'b1);

    // Reset in the middle of a line aborts it.
    push_expected("G", 16'd31415, 1'b0);
    base_strobe = strobe_cnt;
    request("G", 16'd31415, 1'b0);
    for (int i = 0; i < 500 && strobe_cnt - base_strobe < 3; i++) tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
    check("midrst_start_tx", {31'h0, start_tx}, 32'h0);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_done", {31'h0, done}, 32'h0);
    rst = 1'b0;
    base_strobe = strobe_cnt;
    base_done   = done_cnt;
    repeat (20) tick();
    check("no_bytes_after_abort", strobe_cnt - base_strobe, 0);
    check("no_done_after_abort", done_cnt - base_done, 0);
    run_line("H", 16'd908, 1'b0, -1, 1'b0, 1'b1);

    // Randomised lines with a jittery uart ready.
    rand_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      run_line(8'(8'h41 + $urandom_range(0, 8)), 16'($urandom), 1'($urandom), -1, 1'($urandom), 1'b0);
    end
    rand_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
